inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_if.sv | 33 +++
 rtl/inst_fetch.sv | 107 ++++++++++
 tb/tb_inst_fetch.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// Fetch-stage signal bundle: PC-stage inputs, instruction-memory bus and IF/ID outputs.
// The fetch unit takes the master view; the surrounding pipeline/memory takes the slave view.
interface inst_fetch_if #(
    parameter int BIT_W = 32
);
    logic [BIT_W-1:0] i_PC;
    logic [BIT_W-1:0] i_PCPlus4;
    logic             i_flush;
    logic             i_ID_stall;
    logic             o_PC_stall;

    logic             o_IMEM_cen;
    logic [BIT_W-1:0] o_IMEM_addr;
    logic             i_IMEM_stall;
    logic [BIT_W-1:0] i_IMEM_rdata;

    logic             o_ID_valid;
    logic [BIT_W-1:0] o_ID_inst;
    logic [BIT_W-1:0] o_ID_PC;
    logic [BIT_W-1:0] o_ID_PCPlus4;

    modport master (
        input  i_PC, i_PCPlus4, i_flush, i_ID_stall, i_IMEM_stall, i_IMEM_rdata,
        output o_PC_stall, o_IMEM_cen, o_IMEM_addr,
        output o_ID_valid, o_ID_inst, o_ID_PC, o_ID_PCPlus4
    );

    modport slave (
        output i_PC, i_PCPlus4, i_flush, i_ID_stall, i_IMEM_stall, i_IMEM_rdata,
        input  o_PC_stall, o_IMEM_cen, o_IMEM_addr,
        input  o_ID_valid, o_ID_inst, o_ID_PC, o_ID_PCPlus4
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding IMEM request, a one-word skid buffer for
// decode back-pressure, flush handling with drain of an in-flight request, IF/ID register.
module inst_fetch #(
    parameter int BIT_W = 32
) (
    input logic         i_clk,
    input logic         i_rst_n,
    inst_fetch_if.master bus
);
    localparam logic [BIT_W-1:0] NOP = BIT_W'(32'h0000_0013);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t           state;
    logic [BIT_W-1:0] req_pc;
    logic [BIT_W-1:0] req_pc4;
    logic [BIT_W-1:0] hold_buf;
    logic             id_valid;
    logic [BIT_W-1:0] id_inst;
    logic [BIT_W-1:0] id_pc;
    logic [BIT_W-1:0] id_pc4;
    logic             xfer;

    // A word moves into IF/ID only when decode accepts it and no redirect is pending.
    always_comb begin
        xfer = 1'b0;
        if (!bus.i_flush && !bus.i_ID_stall) begin
            case (state)
                S_WAIT:  xfer = !bus.i_IMEM_stall;
                S_HOLD:  xfer = 1'b1;
                default: xfer = 1'b0;
            endcase
        end
    end

    assign bus.o_IMEM_cen   = i_rst_n && (state == S_FETCH) && !bus.i_flush;
    assign bus.o_IMEM_addr  = bus.i_PC;
    assign bus.o_PC_stall   = !i_rst_n || !(bus.i_flush || xfer);

    assign bus.o_ID_valid   = id_valid;
    assign bus.o_ID_inst    = id_inst;
    assign bus.o_ID_PC      = id_pc;
    assign bus.o_ID_PCPlus4 = id_pc4;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= S_FETCH;
            req_pc   <= '0;
            req_pc4  <= '0;
            hold_buf <= '0;
            id_valid <= 1'b0;
            id_inst  <= NOP;
            id_pc    <= '0;
            id_pc4   <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (!bus.i_flush) begin
                        req_pc  <= bus.i_PC;
                        req_pc4 <= bus.i_PCPlus4;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A flushed request still in flight must be drained before re-issuing.
                    if (bus.i_flush) begin
                        state <= bus.i_IMEM_stall ? S_DRAIN : S_FETCH;
                    end else if (!bus.i_IMEM_stall) begin
                        if (bus.i_ID_stall) begin
                            hold_buf <= bus.i_IMEM_rdata;
                            state    <= S_HOLD;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.i_flush || !bus.i_ID_stall) begin
                        state <= S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (!bus.i_IMEM_stall) begin
                        state <= S_FETCH;
                    end
                end
                default: state <= S_FETCH;
            endcase

            if (bus.i_flush) begin
                id_valid <= 1'b0;
            end else if (xfer) begin
                id_valid <= 1'b1;
                id_inst  <= (state == S_HOLD) ? hold_buf : bus.i_IMEM_rdata;
                id_pc    <= req_pc;
                id_pc4   <= req_pc4;
            end else if (!bus.i_ID_stall) begin
                id_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// Randomized self-checking bench for inst_fetch against a transaction-level model,
// preceded by directed scenarios with literal expectations.
module tb_inst_fetch;
    logic clk;
    logic rst_n;

    inst_fetch_if #(.BIT_W(32)) bus ();

    inst_fetch #(.BIT_W(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Model: a request is either absent, in flight (possibly killed), or parked in the buffer.
    bit          m_pend = 1'b0;
    bit          m_dead = 1'b0;
    bit          m_buf  = 1'b0;
    logic [31:0] m_pc   = '0;
    logic [31:0] m_pc4  = '0;
    bit          e_valid = 1'b0;
    logic [31:0] e_inst  = 32'h0000_0013;
    logic [31:0] e_pc    = '0;
    logic [31:0] e_pc4   = '0;
    bit          e_cen, e_stall;

    bit          a_r, a_f, a_ids, a_ims;
    logic [31:0] a_pc, a_pc4;
    logic [31:0] pc_reg   = '0;
    logic [31:0] redirect = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0001_0000) return 32'h0050_0093;
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit f, input bit ids, input bit ims);
        bit idle, avail, xf;
        a_r = r; a_f = f; a_ids = ids; a_ims = ims;
        a_pc = pc_reg; a_pc4 = pc_reg + 32'd4;
        rst_n            = r;
        bus.i_flush      = f;
        bus.i_ID_stall   = ids;
        bus.i_IMEM_stall = ims;
        bus.i_PC         = a_pc;
        bus.i_PCPlus4    = a_pc4;
        bus.i_IMEM_rdata = (m_pend && !m_buf && !ims) ? mem_word(m_pc) : $urandom;
        idle    = !m_pend && !m_buf;
        avail   = (m_pend && !m_buf && !m_dead && !ims) || m_buf;
        xf      = avail && !f && !ids;
        e_cen   = r && idle && !f;
        e_stall = !r || !(f || xf);
        #1;
        check("cen", bus.o_IMEM_cen, e_cen);
        check("pc_stall", bus.o_PC_stall, e_stall);
        if (e_cen) check("addr", bus.o_IMEM_addr, a_pc);
    endtask

    task automatic clock();
        bit idle, avail, xf;
        @(posedge clk);
        idle  = !m_pend && !m_buf;
        avail = (m_pend && !m_buf && !m_dead && !a_ims) || m_buf;
        xf    = avail && !a_f && !a_ids;
        if (!a_r) begin
            m_pend = 0; m_buf = 0; m_dead = 0;
            e_valid = 0; e_inst = 32'h0000_0013; e_pc = '0; e_pc4 = '0;
        end else begin
            if (a_f) e_valid = 0;
            else if (xf) begin
                e_valid = 1; e_inst = mem_word(m_pc); e_pc = m_pc; e_pc4 = m_pc4;
            end else if (!a_ids) e_valid = 0;

            if (idle) begin
                if (!a_f) begin m_pend = 1; m_dead = 0; m_pc = a_pc; m_pc4 = a_pc4; end
            end else if (m_buf) begin
                if (a_f || !a_ids) begin m_buf = 0; m_pend = 0; end
            end else if (a_ims) begin
                if (a_f) m_dead = 1;
            end else begin
                if (!m_dead && !a_f && a_ids) m_buf = 1;
                else m_pend = 0;
                m_dead = 0;
            end

            if (a_f) pc_reg = redirect;
            else if (!e_stall) pc_reg = pc_reg + 32'd4;
        end
        #1;
        check("valid", bus.o_ID_valid, e_valid);
        check("inst", bus.o_ID_inst, e_inst);
        check("pc", bus.o_ID_PC, e_pc);
        check("pc4", bus.o_ID_PCPlus4, e_pc4);
    endtask

    initial begin
        // Reset values and the best-case fetch at 0x00010000.
        drive(0, 0, 0, 0);
        check("rst_cen", bus.o_IMEM_cen, 0);
        check("rst_pc_stall", bus.o_PC_stall, 1);
        clock();
        check("rst_valid", bus.o_ID_valid, 0);
        check("rst_inst", bus.o_ID_inst, 32'h0000_0013);
        check("rst_pc", bus.o_ID_PC, 32'h0);
        pc_reg = 32'h0001_0000;
        drive(1, 0, 0, 0);
        check("c1_cen", bus.o_IMEM_cen, 1);
        check("c1_addr", bus.o_IMEM_addr, 32'h0001_0000);
        clock();
        drive(1, 0, 0, 0);
        check("c2_pc_stall", bus.o_PC_stall, 0);
        clock();
        check("c3_valid", bus.o_ID_valid, 1);
        check("c3_inst", bus.o_ID_inst, 32'h0050_0093);
        check("c3_pc", bus.o_ID_PC, 32'h0001_0000);
        check("c3_pc4", bus.o_ID_PCPlus4, 32'h0001_0004);

        // Memory busy for 3 cycles.
        drive(1, 0, 0, 0);
        check("ws_stall0", bus.o_PC_stall, 1);
        clock();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 1);
            check("ws_stall", bus.o_PC_stall, 1);
            check("ws_cen", bus.o_IMEM_cen, 0);
            clock();
        end
        drive(1, 0, 0, 0);
        check("ws_xfer", bus.o_PC_stall, 0);
        clock();
        check("ws_valid", bus.o_ID_valid, 1);
        check("ws_pc", bus.o_ID_PC, 32'h0001_0004);

        // Decode stall when data returns: buffered, then released without re-request.
        drive(1, 0, 0, 0);
        clock();
        drive(1, 0, 1, 0);
        check("hd_stall", bus.o_PC_stall, 1);
        clock();
        check("hd_frozen_pc", bus.o_ID_PC, 32'h0001_0004);
        drive(1, 0, 1, 1);
        check("hd_cen", bus.o_IMEM_cen, 0);
        clock();
        check("hd_frozen_valid", bus.o_ID_valid, 0);
        drive(1, 0, 0, 0);
        check("hd_rel_stall", bus.o_PC_stall, 0);
        check("hd_rel_cen", bus.o_IMEM_cen, 0);
        clock();
        check("hd_valid", bus.o_ID_valid, 1);
        check("hd_pc", bus.o_ID_PC, 32'h0001_0008);
        check("hd_pc4", bus.o_ID_PCPlus4, 32'h0001_000C);

        // Flush while memory busy: drain, discard, refetch at redirected PC.
        drive(1, 0, 0, 0);
        clock();
        redirect = 32'h0002_0000;
        drive(1, 1, 0, 1);
        check("fl_stall", bus.o_PC_stall, 0);
        clock();
        drive(1, 0, 0, 1);
        check("dr_stall", bus.o_PC_stall, 1);
        check("dr_cen", bus.o_IMEM_cen, 0);
        clock();
        drive(1, 0, 0, 0);
        check("dr_ret_stall", bus.o_PC_stall, 1);
        check("dr_ret_cen", bus.o_IMEM_cen, 0);
        clock();
        check("dr_valid", bus.o_ID_valid, 0);
        drive(1, 0, 0, 0);
        check("rf_cen", bus.o_IMEM_cen, 1);
        check("rf_addr", bus.o_IMEM_addr, 32'h0002_0000);
        clock();
        drive(1, 0, 0, 0);
        clock();
        check("rf_valid", bus.o_ID_valid, 1);
        check("rf_pc", bus.o_ID_PC, 32'h0002_0000);

        // Flush and decode stall together: flush wins.
        redirect = 32'h0003_0000;
        drive(1, 1, 1, 0);
        check("fs_cen", bus.o_IMEM_cen, 0);
        clock();
        check("fs_valid", bus.o_ID_valid, 0);

        // Reset while a request is outstanding.
        drive(1, 0, 0, 0);
        clock();
        drive(0, 0, 0, 1);
        check("mr_cen", bus.o_IMEM_cen, 0);
        check("mr_stall", bus.o_PC_stall, 1);
        clock();
        check("mr_valid", bus.o_ID_valid, 0);
        check("mr_inst", bus.o_ID_inst, 32'h0000_0013);
        check("mr_pc4", bus.o_ID_PCPlus4, 32'h0);
        drive(1, 0, 0, 0);
        check("mr_cen2", bus.o_IMEM_cen, 1);
        check("mr_addr", bus.o_IMEM_addr, 32'h0003_0000);
        clock();

        for (int i = 0; i < 4000; i++) begin
            redirect = $urandom & 32'hFFFF_FFFC;
            drive($urandom_range(0, 199) != 0, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
            clock();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
